srff_bank_arbiter: RTL and testbench
====================================

// Module: srff_bank_arbiter
// PURPOSE
//  Round-robin arbiter that shares one external bank of BANK_W SR flip-flops among NUM_REQ requesters.
//  - Each bank bit is the D/T/JK-built SR flop trio.
//  - Each granted command becomes a one-cycle s/r pulse on one bit.
//  - The block then cross-checks the D, T and JK outputs against a shadow of the expected value.
//  Sits between requesting control logic and the SR flop bank; the only legal driver of the bank's s/r.
// PARAMETERS
//  NUM_REQ  4  number of requesters (>=2)
//  BANK_W   8  number of SR flop bits in the bank (>=2)
//  IDX_W    $clog2(BANK_W)  bit-index width (derived, not overridden)
// PORTS
//  clk             in   1               rising-edge clock
//  reset           in   1               asynchronous, active-high reset
//  req_i           in   NUM_REQ         level request per requester; held until its gnt_o pulse
//  op_i            in   2*NUM_REQ       per-requester op [2i+1:2i]: 00 hold, 01 clear, 10 set, 11 illegal
//  idx_i           in   IDX_W*NUM_REQ   per-requester target bit
//  gnt_o           out  NUM_REQ         one-hot grant, high exactly during DRIVE
//  s_o             out  BANK_W          set pulses to bank, at most one bit high
//  r_o             out  BANK_W          reset pulses to bank, at most one bit high, never with s_o
//  q_d_i           in   BANK_W          bank outputs, D-based SR flops
//  q_t_i           in   BANK_W          bank outputs, T-based SR flops
//  q_jk_i          in   BANK_W          bank outputs, JK-based SR flops
//  err_clr_i       in   1               synchronous clear of sticky error flags
//  busy_o          out  1               high in DRIVE and CHECK
//  done_o          out  1               one-cycle pulse, last cycle of each command
//  err_illegal_o   out  1               sticky: an op 11 was granted
//  err_mismatch_o  out  1               sticky: an output disagreed with shadow
// BEHAVIOUR
//  - Reset (async): state=IDLE, rr pointer=0, shadow=0; every output 0 immediately.
//    The bank must share this reset, so shadow==bank==0 after reset.
//  - FSM IDLE->DRIVE->CHECK->IDLE. All outputs are registered or decoded from state registers.
//  - IDLE: on an edge with any req_i high, pick the first requester at or after ptr (wrapping modulo NUM_REQ).
//    At that edge, latch its op/idx into cmd registers; go to DRIVE.
//  - DRIVE (1 cycle): gnt_o[winner]=1.
//    * set: s_o[idx]=1.
//    * clear: r_o[idx]=1.
//    * hold and illegal: s_o=r_o=0. The bank is never driven S=R=1.
//    * illegal also sets err_illegal_o at the DRIVE->CHECK edge.
//    * shadow[idx] updates at the same edge: set->1, clear->0, otherwise unchanged.
//  - CHECK (1 cycle): done_o=1. At the CHECK->IDLE edge:
//    * if any of q_d_i[idx], q_t_i[idx], q_jk_i[idx] != shadow[idx], set err_mismatch_o;
//    * ptr<=winner+1 mod NUM_REQ.
//  - Latency: request seen at edge E0 -> grant/pulse in cycle E0..E1 -> done_o in cycle E1..E2.
//    Peak throughput: one command per 3 cycles.
//  - Requests arriving in DRIVE or CHECK are not sampled until the next IDLE edge.
//    A request dropped before grant is lost silently.
//  - Winner's req_i is ignored after gnt_o. Same requester can win again only after every other pending requester.
//  - Errors: err_clr_i clears both flags. If a new error is detected on the same edge as err_clr_i, the error wins (flag stays 1).
//  - Reset mid-DRIVE: s_o/r_o drop asynchronously. The partial pulse is discarded; no done_o.
// CONFIGURATION
//  SRFF_ARB_CHECK_EN defined:
//    full behaviour above, CHECK state present.
//  SRFF_ARB_CHECK_EN undefined:
//    - no CHECK state: DRIVE->IDLE, done_o pulses during DRIVE;
//    - err_mismatch_o tied 0; q_*_i unused;
//    - shadow register removed;
//    - throughput one command per 2 cycles.
// STRUCTURE
//  Package srff_arb_pkg:
//    - state enum (ST_IDLE, ST_DRIVE, ST_CHECK);
//    - op codes (OP_HOLD=2'b00, OP_CLR=2'b01, OP_SET=2'b10, OP_ILL=2'b11).
//  Sub-module srff_rr_pick: combinational (req, ptr) -> one-hot winner + valid + winner index, parameterised by NUM_REQ.
//  Top holds FSM, cmd/ptr/shadow registers, s/r decode and compare.
// TESTING
//  1. Reset during DRIVE of a set to bit 5 -> s_o=0 same cycle; busy_o=0; both errs=0; no done_o.
//  2. req_i=4'b0001, op=set, idx=3, bank correct
//     -> gnt_o=4'b0001 and s_o=8'h08 for one cycle; done_o next cycle; err_mismatch_o=0.
//  3. req_i=4'b1111, each set distinct idx 0..3 -> grants 0,1,2,3 three cycles apart; fifth grant returns to 0.
//  4. Requester 2 op=11 -> s_o=r_o=0; err_illegal_o=1 and held; err_clr_i pulse -> 0.
//  5. Set bit 1 with q_t_i[1] forced 0 during CHECK -> err_mismatch_o=1 after CHECK edge.
//     Hold on bit 1 with outputs matching -> flag stays 1 (sticky).
//  6. Macro undefined: test 2 gives done_o during the gnt_o cycle; test 5 leaves err_mismatch_o=0.

Source files
------------

// File: rtl/srff_arb_pkg.sv
// Shared types for the SR flop bank arbiter: FSM states and command op codes.
// Imported by srff_rr_pick and srff_bank_arbiter.
package srff_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   localparam logic [1:0] OP_HOLD = 2'b00;
   localparam logic [1:0] OP_CLR  = 2'b01;
   localparam logic [1:0] OP_SET  = 2'b10;
   localparam logic [1:0] OP_ILL  = 2'b11;

endpackage

// File: rtl/srff_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr wins.
// Produces one-hot grant, valid and the winner index.
module srff_rr_pick
   import srff_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int PW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic               vld,
   output logic [PW-1:0]      win
);

   logic [PW-1:0] cand;

   always_comb begin
      gnt  = '0;
      vld  = 1'b0;
      win  = '0;
      cand = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = PW'((int'(ptr) + i) % NUM_REQ);
         if (!vld && req[cand]) begin
            vld       = 1'b1;
            win       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/srff_bank_arbiter.sv
// Round-robin arbiter driving one-cycle s/r pulses into a shared SR flop bank.
// Define SRFF_ARB_CHECK_EN to add the CHECK state, shadow and mismatch flag.
module srff_bank_arbiter
   import srff_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int BANK_W  = 8,
   localparam int IDX_W   = $clog2(BANK_W)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_i,
   input  logic [2*NUM_REQ-1:0]     op_i,
   input  logic [IDX_W*NUM_REQ-1:0] idx_i,
   output logic [NUM_REQ-1:0]       gnt_o,
   output logic [BANK_W-1:0]        s_o,
   output logic [BANK_W-1:0]        r_o,
   input  logic [BANK_W-1:0]        q_d_i,
   input  logic [BANK_W-1:0]        q_t_i,
   input  logic [BANK_W-1:0]        q_jk_i,
   input  logic                     err_clr_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_illegal_o,
   output logic                     err_mismatch_o
);

   localparam int PW = $clog2(NUM_REQ);

   state_t              state;
   logic [PW-1:0]       ptr;
   logic [PW-1:0]       win;
   logic [PW-1:0]       next_ptr;
   logic [1:0]          cmd_op;

   logic [NUM_REQ-1:0]  pick_gnt;
   logic                pick_vld;
   logic [PW-1:0]       pick_win;
   logic [1:0]          op_sel;
   logic [IDX_W-1:0]    idx_sel;
   logic [BANK_W-1:0]   sel_oh;

   srff_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req (req_i),
      .ptr (ptr),
      .gnt (pick_gnt),
      .vld (pick_vld),
      .win (pick_win)
   );

   always_comb begin
      op_sel  = OP_HOLD;
      idx_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_gnt[i]) begin
            op_sel  = op_i[2*i +: 2];
            idx_sel = idx_i[IDX_W*i +: IDX_W];
         end
      end
   end

   assign sel_oh   = BANK_W'(1) << idx_sel;
   assign next_ptr = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

`ifdef SRFF_ARB_CHECK_EN
   logic [IDX_W-1:0]  cmd_idx;
   logic [BANK_W-1:0] shadow;
   logic              mism;

   assign mism = (q_d_i[cmd_idx]  != shadow[cmd_idx]) |
                 (q_t_i[cmd_idx]  != shadow[cmd_idx]) |
                 (q_jk_i[cmd_idx] != shadow[cmd_idx]);
`else
   logic unused_q;

   assign unused_q       = ^{q_d_i, q_t_i, q_jk_i};
   assign err_mismatch_o = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         ptr           <= '0;
         win           <= '0;
         cmd_op        <= OP_HOLD;
         gnt_o         <= '0;
         s_o           <= '0;
         r_o           <= '0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         err_illegal_o <= 1'b0;
`ifdef SRFF_ARB_CHECK_EN
         cmd_idx        <= '0;
         shadow         <= '0;
         err_mismatch_o <= 1'b0;
`endif
      end else begin
         done_o <= 1'b0;
         // clear first so a same-edge error set below takes priority
         if (err_clr_i) begin
            err_illegal_o  <= 1'b0;
`ifdef SRFF_ARB_CHECK_EN
            err_mismatch_o <= 1'b0;
`endif
         end
         unique case (state)
            ST_IDLE: begin
               if (pick_vld) begin
                  state  <= ST_DRIVE;
                  win    <= pick_win;
                  cmd_op <= op_sel;
                  gnt_o  <= pick_gnt;
                  busy_o <= 1'b1;
                  s_o    <= (op_sel == OP_SET) ? sel_oh : '0;
                  r_o    <= (op_sel == OP_CLR) ? sel_oh : '0;
`ifdef SRFF_ARB_CHECK_EN
                  cmd_idx <= idx_sel;
`else
                  done_o  <= 1'b1;
`endif
               end
            end
            ST_DRIVE: begin
               gnt_o <= '0;
               s_o   <= '0;
               r_o   <= '0;
               if (cmd_op == OP_ILL)
                  err_illegal_o <= 1'b1;
`ifdef SRFF_ARB_CHECK_EN
               if (cmd_op == OP_SET)
                  shadow[cmd_idx] <= 1'b1;
               else if (cmd_op == OP_CLR)
                  shadow[cmd_idx] <= 1'b0;
               state  <= ST_CHECK;
               done_o <= 1'b1;
`else
               state  <= ST_IDLE;
               busy_o <= 1'b0;
               ptr    <= next_ptr;
`endif
            end
`ifdef SRFF_ARB_CHECK_EN
            ST_CHECK: begin
               state  <= ST_IDLE;
               busy_o <= 1'b0;
               ptr    <= next_ptr;
               if (mism)
                  err_mismatch_o <= 1'b1;
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_srff_bank_arbiter.sv
// Directed bench for srff_bank_arbiter with a behavioural SR flop bank.
// Expectations follow SRFF_ARB_CHECK_EN when it is defined.
module tb_srff_bank_arbiter;

`ifdef SRFF_ARB_CHECK_EN
   localparam bit CHK = 1'b1;
   localparam int CMD = 3;
`else
   localparam bit CHK = 1'b0;
   localparam int CMD = 2;
`endif

   logic        clk;
   logic        reset;
   logic [3:0]  req_i;
   logic [7:0]  op_i;
   logic [11:0] idx_i;
   logic [3:0]  gnt_o;
   logic [7:0]  s_o;
   logic [7:0]  r_o;
   logic [7:0]  q_d_i;
   logic [7:0]  q_t_i;
   logic [7:0]  q_jk_i;
   logic        err_clr_i;
   logic        busy_o;
   logic        done_o;
   logic        err_illegal_o;
   logic        err_mismatch_o;

   logic [7:0]  bq_d, bq_t, bq_jk, t_fault;

   int n_chk  = 0;
   int n_pass = 0;

   srff_bank_arbiter #(
      .NUM_REQ (4),
      .BANK_W  (8)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .req_i          (req_i),
      .op_i           (op_i),
      .idx_i          (idx_i),
      .gnt_o          (gnt_o),
      .s_o            (s_o),
      .r_o            (r_o),
      .q_d_i          (q_d_i),
      .q_t_i          (q_t_i),
      .q_jk_i         (q_jk_i),
      .err_clr_i      (err_clr_i),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .err_illegal_o  (err_illegal_o),
      .err_mismatch_o (err_mismatch_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural bank sharing the arbiter reset
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         bq_d  <= '0;
         bq_t  <= '0;
         bq_jk <= '0;
      end else begin
         bq_d  <= (bq_d  | s_o) & ~r_o;
         bq_t  <= (bq_t  | s_o) & ~r_o;
         bq_jk <= (bq_jk | s_o) & ~r_o;
      end
   end

   assign q_d_i  = bq_d;
   assign q_t_i  = bq_t ^ t_fault;
   assign q_jk_i = bq_jk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (gnt_o != 4'd0) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic do_reset();
      req_i = '0;
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(1);
   endtask

   task automatic test_reset();
      req_i     = '0;
      op_i      = '0;
      idx_i     = '0;
      err_clr_i = 1'b0;
      t_fault   = '0;
      reset     = 1'b1;
      step(2);
      n_chk++;
      if ({gnt_o, s_o, r_o} !== 20'd0)
         $display("FAIL reset_gsr got %h want 0", {gnt_o, s_o, r_o});
      else n_pass++;
      n_chk++;
      if ({busy_o, done_o} !== 2'b00)
         $display("FAIL reset_busy_done got %b want 00", {busy_o, done_o});
      else n_pass++;
      n_chk++;
      if ({err_illegal_o, err_mismatch_o} !== 2'b00)
         $display("FAIL reset_errs got %b want 00",
                  {err_illegal_o, err_mismatch_o});
      else n_pass++;
      reset = 1'b0;
      step(1);
      n_chk++;
      if (busy_o !== 1'b0)
         $display("FAIL reset_idle busy got %b want 0", busy_o);
      else n_pass++;
   endtask

   task automatic test_reset_mid_drive();
      bit ok;
      req_i = 4'b0001;
      op_i  = 8'b00_00_00_10;
      idx_i = {3'd0, 3'd0, 3'd0, 3'd5};
      wait_gnt(ok);
      n_chk++;
      if (!ok || s_o !== 8'h20)
         $display("FAIL mid_drive_pulse got s=%h want 20", s_o);
      else n_pass++;
      #2;
      reset = 1'b1;
      req_i = '0;
      #1;
      n_chk++;
      if (s_o !== 8'h00 || gnt_o !== 4'd0)
         $display("FAIL mid_drive_drop got s=%h g=%b want 0", s_o, gnt_o);
      else n_pass++;
      n_chk++;
      if ({busy_o, done_o, err_illegal_o, err_mismatch_o} !== 4'd0)
         $display("FAIL mid_drive_flags got %b want 0000",
                  {busy_o, done_o, err_illegal_o, err_mismatch_o});
      else n_pass++;
      #1;
      reset = 1'b0;
      step(1);
      n_chk++;
      if (done_o !== 1'b0 || bq_d !== 8'h00)
         $display("FAIL mid_drive_nodone got d=%b bank=%h want 0 00",
                  done_o, bq_d);
      else n_pass++;
      step(2);
   endtask

   task automatic test_single_set();
      bit ok;
      req_i = 4'b0001;
      op_i  = 8'b00_00_00_10;
      idx_i = {3'd0, 3'd0, 3'd0, 3'd3};
      wait_gnt(ok);
      req_i = '0;
      n_chk++;
      if (!ok || gnt_o !== 4'b0001)
         $display("FAIL set_gnt got %b want 0001", gnt_o);
      else n_pass++;
      n_chk++;
      if (s_o !== 8'h08 || r_o !== 8'h00)
         $display("FAIL set_pulse got s=%h r=%h want 08 00", s_o, r_o);
      else n_pass++;
      n_chk++;
      if (busy_o !== 1'b1 || done_o !== !CHK)
         $display("FAIL set_drive_bd got %b%b want 1%b",
                  busy_o, done_o, !CHK);
      else n_pass++;
      step(1);
      n_chk++;
      if (s_o !== 8'h00 || gnt_o !== 4'd0)
         $display("FAIL set_one_cycle got s=%h g=%b want 0", s_o, gnt_o);
      else n_pass++;
      n_chk++;
      if (done_o !== CHK || busy_o !== CHK)
         $display("FAIL set_after_bd got %b%b want %b%b",
                  busy_o, done_o, CHK, CHK);
      else n_pass++;
      if (CHK) step(1);
      n_chk++;
      if ({busy_o, done_o, err_mismatch_o} !== 3'b000)
         $display("FAIL set_end got %b want 000",
                  {busy_o, done_o, err_mismatch_o});
      else n_pass++;
      n_chk++;
      if (bq_d !== 8'h08)
         $display("FAIL set_bank got %h want 08", bq_d);
      else n_pass++;
      step(1);
   endtask

   task automatic test_clear();
      bit ok;
      req_i = 4'b0010;
      op_i  = 8'b00_00_01_00;
      idx_i = {3'd0, 3'd0, 3'd3, 3'd0};
      wait_gnt(ok);
      req_i = '0;
      n_chk++;
      if (!ok || gnt_o !== 4'b0010 || r_o !== 8'h08 || s_o !== 8'h00)
         $display("FAIL clr_pulse got g=%b s=%h r=%h want 0010 00 08",
                  gnt_o, s_o, r_o);
      else n_pass++;
      step(CMD);
      n_chk++;
      if (bq_d !== 8'h00 || err_mismatch_o !== 1'b0)
         $display("FAIL clr_end got bank=%h mm=%b want 00 0",
                  bq_d, err_mismatch_o);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      int gcyc[5];
      logic [3:0] g[5];
      int k;
      do_reset();
      req_i = 4'b1111;
      op_i  = 8'b10_10_10_10;
      idx_i = {3'd3, 3'd2, 3'd1, 3'd0};
      k = 0;
      for (int c = 0; c < 40 && k < 5; c++) begin
         @(posedge clk);
         #1;
         if (gnt_o != 4'd0) begin
            g[k]    = gnt_o;
            gcyc[k] = c;
            k++;
         end
      end
      req_i = '0;
      n_chk++;
      if (k != 5)
         $display("FAIL rr_count got %0d grants want 5", k);
      else n_pass++;
      for (int i = 0; i < k; i++) begin
         n_chk++;
         if (g[i] !== 4'(1 << (i % 4)))
            $display("FAIL rr_order[%0d] got %b want %b",
                     i, g[i], 4'(1 << (i % 4)));
         else n_pass++;
         if (i > 0) begin
            n_chk++;
            if (gcyc[i] - gcyc[i-1] != CMD)
               $display("FAIL rr_gap[%0d] got %0d want %0d",
                        i, gcyc[i] - gcyc[i-1], CMD);
            else n_pass++;
         end
      end
      step(CMD + 1);
      n_chk++;
      if (bq_d !== 8'h0f || busy_o !== 1'b0)
         $display("FAIL rr_bank got %h busy=%b want 0f 0", bq_d, busy_o);
      else n_pass++;
   endtask

   task automatic test_illegal();
      bit ok;
      req_i = 4'b0100;
      op_i  = 8'b00_11_00_00;
      idx_i = {3'd0, 3'd6, 3'd0, 3'd0};
      wait_gnt(ok);
      req_i = '0;
      n_chk++;
      if (!ok || gnt_o !== 4'b0100 || s_o !== 8'h00 || r_o !== 8'h00)
         $display("FAIL ill_drive got g=%b s=%h r=%h want 0100 00 00",
                  gnt_o, s_o, r_o);
      else n_pass++;
      n_chk++;
      if (err_illegal_o !== 1'b0)
         $display("FAIL ill_early got %b want 0", err_illegal_o);
      else n_pass++;
      step(1);
      n_chk++;
      if (err_illegal_o !== 1'b1)
         $display("FAIL ill_set got %b want 1", err_illegal_o);
      else n_pass++;
      step(3);
      n_chk++;
      if (err_illegal_o !== 1'b1)
         $display("FAIL ill_sticky got %b want 1", err_illegal_o);
      else n_pass++;
      err_clr_i = 1'b1;
      step(1);
      err_clr_i = 1'b0;
      n_chk++;
      if (err_illegal_o !== 1'b0 || bq_d[6] !== 1'b0)
         $display("FAIL ill_clr got %b bit6=%b want 0 0",
                  err_illegal_o, bq_d[6]);
      else n_pass++;
   endtask

   task automatic test_mismatch();
      bit ok;
      req_i = 4'b0001;
      op_i  = 8'b00_00_00_10;
      idx_i = {3'd0, 3'd0, 3'd0, 3'd1};
      wait_gnt(ok);
      req_i   = '0;
      t_fault = 8'h02;
      step(1);
      n_chk++;
      if (!ok || err_mismatch_o !== 1'b0)
         $display("FAIL mm_early got %b want 0", err_mismatch_o);
      else n_pass++;
      step(1);
      t_fault = '0;
      n_chk++;
      if (err_mismatch_o !== CHK)
         $display("FAIL mm_set got %b want %b", err_mismatch_o, CHK);
      else n_pass++;
      step(1);
      req_i = 4'b0001;
      op_i  = 8'b00_00_00_00;
      wait_gnt(ok);
      req_i = '0;
      n_chk++;
      if (!ok || s_o !== 8'h00 || r_o !== 8'h00)
         $display("FAIL hold_pulse got s=%h r=%h want 00 00", s_o, r_o);
      else n_pass++;
      step(CMD);
      n_chk++;
      if (err_mismatch_o !== CHK || bq_d[1] !== 1'b1)
         $display("FAIL mm_sticky got %b bit1=%b want %b 1",
                  err_mismatch_o, bq_d[1], CHK);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_reset_mid_drive();
      test_single_set();
      test_clear();
      test_round_robin();
      test_illegal();
      test_mismatch();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
